// File: rtl/reg_file_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_writeback_pkg
// Description : Shared definitions for the register-file writeback front end:
//               default widths, the writeback request record, the writeback
//               source encodings and the source-selection helper.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_writeback_pkg;

    // Default widths of the register file datapath.
    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_NUM_REGS   = 16;
    localparam int WB_SEL_WIDTH  = $clog2(WB_NUM_REGS);

    // One writeback request: destination register and value.
    typedef struct packed {
        logic [WB_SEL_WIDTH-1:0]  sel;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

    // Which source owns the write port in a given cycle.
    localparam logic [1:0] WB_SRC_NONE = 2'd0;
    localparam logic [1:0] WB_SRC_ALU  = 2'd1;
    localparam logic [1:0] WB_SRC_LD   = 2'd2;
    localparam logic [1:0] WB_SRC_MD   = 2'd3;

    // The ALU always wins; otherwise at most one of the arbiter grants is set.
    function automatic logic [1:0] wb_grant_src(
        input logic alu_valid,
        input logic gnt_ld,
        input logic gnt_md
    );
        logic [1:0] src;
        src = WB_SRC_NONE;
        if (alu_valid)   src = WB_SRC_ALU;
        else if (gnt_ld) src = WB_SRC_LD;
        else if (gnt_md) src = WB_SRC_MD;
        return src;
    endfunction

endpackage : reg_file_writeback_pkg
`default_nettype wire

// File: rtl/reg_file_writeback_rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-requester round-robin arbiter. The preference pointer
//               only moves when both requesters ask in the same cycle and a
//               grant is actually issued, so an uncontended requester never
//               disturbs fairness. Grants are combinational.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_block       - higher-priority user owns the resource
//               i_req_a/b     - requests
//               o_gnt_a/b     - grants (at most one high, both low in reset)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2 (
    input  logic clk,
    input  logic rst,
    input  logic i_block,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    // 0: requester A preferred on contention, 1: requester B preferred.
    logic r_ptr_b;
    logic w_enable;
    logic w_contend;

    always_comb begin
        w_enable  = ~rst & ~i_block;
        w_contend = i_req_a & i_req_b;
        o_gnt_a   = w_enable & i_req_a & (~i_req_b | ~r_ptr_b);
        o_gnt_b   = w_enable & i_req_b & (~i_req_a |  r_ptr_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_b <= 1'b0;
        end else if (w_enable && w_contend) begin
            r_ptr_b <= ~r_ptr_b;
        end
    end

endmodule : rr_arbiter_2
`default_nettype wire

// File: rtl/reg_file_writeback.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_writeback
// Description : Writer-side front end of the register file's single write
//               port. Merges ALU (fixed latency, never stalls), load and
//               mul/div (valid/ready) writebacks into one registered write
//               stream and tracks registers with outstanding long-latency
//               writes in busy_mask.
// Ports       : clk, rst                  - clock, synchronous active-high reset
//               alu_valid/sel/data        - ALU result, always accepted
//               ld_valid/ready/sel/data   - load result handshake
//               md_valid/ready/sel/data   - mul/div result handshake
//               claim_en/claim_sel        - issue-stage destination reservation
//               write_en/sel/data         - register file write port (1 cycle)
//               busy_mask                 - outstanding ld/md destinations
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_writeback
    import reg_file_writeback_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int NUM_REGS   = WB_NUM_REGS,
    parameter int SEL_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [SEL_WIDTH-1:0]  alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [SEL_WIDTH-1:0]  ld_sel,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [SEL_WIDTH-1:0]  md_sel,
    input  logic [DATA_WIDTH-1:0] md_data,
    input  logic                  claim_en,
    input  logic [SEL_WIDTH-1:0]  claim_sel,
    output logic                  write_en,
    output logic [SEL_WIDTH-1:0]  write_sel,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [NUM_REGS-1:0]   busy_mask
);

    // Request record sized by this instance's parameters.
    typedef struct packed {
        logic [SEL_WIDTH-1:0]  sel;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    localparam logic [SEL_WIDTH-1:0] c_SEL_ZERO = '0;

    logic                  w_gnt_ld;
    logic                  w_gnt_md;
    logic                  w_ld_xfer;
    logic                  w_md_xfer;
    logic [1:0]            w_src;
    req_t                  w_req;
    logic                  w_write;

    logic                  r_write_en;
    logic [SEL_WIDTH-1:0]  r_write_sel;
    logic [DATA_WIDTH-1:0] r_write_data;
    logic [NUM_REGS-1:0]   r_busy;

    // ------------------------------------------------------------------
    // Arbitration: the ALU blocks the arbiter outright, so the pointer is
    // frozen while the ALU holds the port.
    // ------------------------------------------------------------------
    rr_arbiter_2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_block (alu_valid),
        .i_req_a (ld_valid),
        .i_req_b (md_valid),
        .o_gnt_a (w_gnt_ld),
        .o_gnt_b (w_gnt_md)
    );

    assign ld_ready  = w_gnt_ld;
    assign md_ready  = w_gnt_md;
    assign w_ld_xfer = ld_valid & w_gnt_ld;
    assign w_md_xfer = md_valid & w_gnt_md;

    // ------------------------------------------------------------------
    // Source mux. Requests to register 0 are accepted but produce no write.
    // ------------------------------------------------------------------
    always_comb begin
        w_src = wb_grant_src(alu_valid, w_gnt_ld, w_gnt_md);
        w_req = '0;
        case (w_src)
            WB_SRC_ALU: w_req = '{sel: alu_sel, data: alu_data};
            WB_SRC_LD:  w_req = '{sel: ld_sel,  data: ld_data};
            WB_SRC_MD:  w_req = '{sel: md_sel,  data: md_data};
            default:    w_req = '0;
        endcase
        w_write = (w_src != WB_SRC_NONE) && (w_req.sel != c_SEL_ZERO);
    end

    // Output register; sel/data only move on an actual write so the port
    // shows the last written value while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write_en   <= 1'b0;
            r_write_sel  <= '0;
            r_write_data <= '0;
        end else begin
            r_write_en <= w_write;
            if (w_write) begin
                r_write_sel  <= w_req.sel;
                r_write_data <= w_req.data;
            end
        end
    end

    assign write_en   = r_write_en;
    assign write_sel  = r_write_sel;
    assign write_data = r_write_data;

    // ------------------------------------------------------------------
    // Busy scoreboard. A claim in the same cycle as a clear wins because it
    // belongs to a newer producer of that register. Register 0 never busy.
    // ------------------------------------------------------------------
    assign r_busy[0] = 1'b0;

    generate
        for (genvar i = 1; i < NUM_REGS; i++) begin : g_busy
            localparam logic [SEL_WIDTH-1:0] c_IDX = SEL_WIDTH'(i);
            logic w_claim;
            logic w_clear;

            assign w_claim = claim_en & (claim_sel == c_IDX);
            assign w_clear = (w_ld_xfer & (ld_sel == c_IDX))
                           | (w_md_xfer & (md_sel == c_IDX));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_busy[i] <= 1'b0;
                end else begin
                    r_busy[i] <= w_claim | (r_busy[i] & ~w_clear);
                end
            end
        end
    endgenerate

    assign busy_mask = r_busy;

endmodule : reg_file_writeback
`default_nettype wire

// File: tb/tb_reg_file_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_writeback
// Description : Scoreboard bench for reg_file_writeback. Directed stimulus
//               pushes each expected register write into a queue; a monitor
//               pops and compares whenever write_en is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_writeback;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int SW = 4;

    typedef struct {
        logic [SW-1:0] sel;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          alu_valid;
    logic [SW-1:0] alu_sel;
    logic [DW-1:0] alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [SW-1:0] ld_sel;
    logic [DW-1:0] ld_data;
    logic          md_valid;
    logic          md_ready;
    logic [SW-1:0] md_sel;
    logic [DW-1:0] md_data;
    logic          claim_en;
    logic [SW-1:0] claim_sel;
    logic          write_en;
    logic [SW-1:0] write_sel;
    logic [DW-1:0] write_data;
    logic [NR-1:0] busy_mask;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    reg_file_writeback #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .SEL_WIDTH  (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_sel    (alu_sel),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_sel     (ld_sel),
        .ld_data    (ld_data),
        .md_valid   (md_valid),
        .md_ready   (md_ready),
        .md_sel     (md_sel),
        .md_data    (md_data),
        .claim_en   (claim_en),
        .claim_sel  (claim_sel),
        .write_en   (write_en),
        .write_sel  (write_sel),
        .write_data (write_data),
        .busy_mask  (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [SW-1:0] sel, input logic [DW-1:0] data);
        exp_t e;
        e.sel  = sel;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every write on the port must match the oldest expected write.
    always @(posedge clk) begin
        #1;
        if (write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_sel", {60'd0, write_sel}, 64'hF);
                failures++;
                checks++;
                $display("FAIL unexpected_write: write_en=1 with no pending expectation (sel=%0d)", write_sel);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("write_sel",  {60'd0, write_sel},  {60'd0, e.sel});
                chk("write_data", {32'd0, write_data}, {32'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; alu_valid = 0; alu_sel = 0; alu_data = 0;
        ld_valid = 0; ld_sel = 0; ld_data = 0;
        md_valid = 0; md_sel = 0; md_data = 0;
        claim_en = 0; claim_sel = 0;

        // 1. Reset with a load pending: no acceptance, clean state afterwards.
        ld_valid = 1; ld_sel = 4'd2; ld_data = 32'hAAAA_0000;
        #1;
        chk("rst_ld_ready", {63'd0, ld_ready}, 64'd0);
        cycle(); cycle();
        chk("rst_write_en", {63'd0, write_en}, 64'd0);
        chk("rst_write_sel", {60'd0, write_sel}, 64'd0);
        rst = 0; ld_valid = 0;
        cycle();
        chk("post_rst_write_en", {63'd0, write_en}, 64'd0);
        chk("post_rst_busy", {48'd0, busy_mask}, 64'h0000);

        // 2. ALU pre-empts a load; the load wins the next idle cycle.
        alu_valid = 1; alu_sel = 4'd3; alu_data = 32'hDEADBEEF;
        ld_valid = 1; ld_sel = 4'd2; ld_data = 32'h0000_1111;
        #1;
        chk("alu_blocks_ld", {63'd0, ld_ready}, 64'd0);
        push(4'd3, 32'hDEADBEEF);
        cycle();
        chk("alu_write_en", {63'd0, write_en}, 64'd1);
        alu_valid = 0;
        #1;
        chk("ld_after_alu_ready", {63'd0, ld_ready}, 64'd1);
        push(4'd2, 32'h0000_1111);
        cycle();
        ld_valid = 0;

        // 3. Contention: LD, MD, LD, MD starting from the reset pointer.
        ld_valid = 1; ld_sel = 4'd4; ld_data = 32'h4000_0000;
        md_valid = 1; md_sel = 4'd6; md_data = 32'h6000_0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk("rr_ld_ready", {62'd0, ld_ready, md_ready}, 64'b10);
                push(4'd4, ld_data);
                cycle();
                ld_data = ld_data + 32'd1;
            end else begin
                chk("rr_md_ready", {62'd0, ld_ready, md_ready}, 64'b01);
                push(4'd6, md_data);
                cycle();
                md_data = md_data + 32'd1;
            end
        end
        ld_valid = 0; md_valid = 0;
        cycle();

        // 4. Write to register 0 is acknowledged but dropped; port holds.
        md_valid = 1; md_sel = 4'd0; md_data = 32'h0000_1234;
        #1;
        chk("md_r0_ready", {63'd0, md_ready}, 64'd1);
        cycle();
        md_valid = 0;
        chk("md_r0_write_en", {63'd0, write_en}, 64'd0);
        chk("hold_write_sel", {60'd0, write_sel}, 64'd6);
        chk("hold_write_data", {32'd0, write_data}, 64'h6000_0001);

        // 5. Scoreboard: claim, claim-beats-clear, clear, claim of reg 0.
        claim_en = 1; claim_sel = 4'd5;
        cycle();
        claim_en = 0;
        chk("claim5_busy", {48'd0, busy_mask}, 64'h0020);
        ld_valid = 1; ld_sel = 4'd5; ld_data = 32'h5555_0001;
        claim_en = 1; claim_sel = 4'd5;
        push(4'd5, 32'h5555_0001);
        cycle();
        claim_en = 0;
        chk("claim_wins_busy", {48'd0, busy_mask}, 64'h0020);
        ld_data = 32'h5555_0002;
        push(4'd5, 32'h5555_0002);
        cycle();
        ld_valid = 0;
        chk("clear5_busy", {48'd0, busy_mask}, 64'h0000);
        claim_en = 1; claim_sel = 4'd0;
        cycle();
        claim_en = 0;
        chk("claim0_ignored", {48'd0, busy_mask}, 64'h0000);

        // 6. ALU write never clears a busy bit; an md transfer does.
        claim_en = 1; claim_sel = 4'd7;
        cycle();
        claim_en = 0;
        chk("claim7_busy", {48'd0, busy_mask}, 64'h0080);
        alu_valid = 1; alu_sel = 4'd7; alu_data = 32'h7777_7777;
        push(4'd7, 32'h7777_7777);
        cycle();
        alu_valid = 0;
        chk("alu_keeps_busy", {48'd0, busy_mask}, 64'h0080);
        chk("alu7_write_en", {63'd0, write_en}, 64'd1);
        md_valid = 1; md_sel = 4'd7; md_data = 32'h7000_0007;
        push(4'd7, 32'h7000_0007);
        cycle();
        md_valid = 0;
        chk("md_clears_busy", {48'd0, busy_mask}, 64'h0000);

        // Mid-stream reset discards the scoreboard and any pending request.
        claim_en = 1; claim_sel = 4'd8;
        cycle();
        claim_en = 0;
        chk("claim8_busy", {48'd0, busy_mask}, 64'h0100);
        rst = 1; ld_valid = 1; ld_sel = 4'd9; ld_data = 32'h9999_9999;
        #1;
        chk("midrst_ld_ready", {63'd0, ld_ready}, 64'd0);
        cycle();
        rst = 0; ld_valid = 0;
        chk("midrst_write_en", {63'd0, write_en}, 64'd0);
        chk("midrst_busy", {48'd0, busy_mask}, 64'h0000);
        cycle(); cycle();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_file_writeback
`default_nettype wire
